// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between a show-ahead FIFO read port and a downstream
// valid/ready stream. The reader takes the master side.
interface fifo_stream_reader_if #(
    parameter int W = 8
);
    logic         fifo_empty;
    logic [W-1:0] fifo_rd_data;
    logic         fifo_rd_en;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  flush,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data,
        output out_last
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output flush,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO into a valid/ready stream through a 2-entry
// skid buffer. One-cycle latency, one word per cycle sustained, and a
// free-running beat counter that marks the last beat of each burst.
// The pop request never looks at out_ready; the second buffer entry absorbs
// the word that may already be in flight when downstream stalls.
module fifo_stream_reader #(
    parameter int W         = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                 rd_clk,
    input  logic                 rd_reset_n,
    fifo_stream_reader_if.master bus
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic [1:0]    r_cnt;
    logic [W-1:0]  r_entry0;
    logic [W-1:0]  r_entry1;
    logic [BW-1:0] r_beat_cnt;

    logic [1:0]    w_cnt_nxt;
    logic [W-1:0]  w_entry0_nxt;
    logic [W-1:0]  w_entry1_nxt;
    logic [BW-1:0] w_beat_cnt_nxt;

    logic w_push;
    logic w_pop;
    logic w_valid;

    // Pop the FIFO whenever a slot is free; reset and flush both block it.
    assign w_push  = !bus.fifo_empty && (r_cnt != 2'd2) && !bus.flush && rd_reset_n;
    assign w_valid = (r_cnt != 2'd0);
    assign w_pop   = w_valid && bus.out_ready;

    assign bus.fifo_rd_en = w_push;
    assign bus.out_valid  = w_valid;
    assign bus.out_data   = r_entry0;
    assign bus.out_last   = w_valid && (r_beat_cnt == LAST_BEAT);

    // Next-state for the buffer occupancy, entries and burst position.
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_entry0_nxt   = r_entry0;
        w_entry1_nxt   = r_entry1;
        w_beat_cnt_nxt = r_beat_cnt;

        if (bus.flush) begin
            w_cnt_nxt      = 2'd0;
            w_entry0_nxt   = {W{1'b0}};
            w_entry1_nxt   = {W{1'b0}};
            w_beat_cnt_nxt = {BW{1'b0}};
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_push) begin
                        w_entry0_nxt = bus.fifo_rd_data;
                        w_cnt_nxt    = 2'd1;
                    end else begin
                        w_cnt_nxt    = 2'd0;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        // Head leaves as the new word arrives: new word becomes head.
                        w_entry0_nxt = bus.fifo_rd_data;
                        w_cnt_nxt    = 2'd1;
                    end else if (w_push) begin
                        w_entry1_nxt = bus.fifo_rd_data;
                        w_cnt_nxt    = 2'd2;
                    end else if (w_pop) begin
                        w_cnt_nxt    = 2'd0;
                    end else begin
                        w_cnt_nxt    = 2'd1;
                    end
                end
                2'd2: begin
                    // Full: no push can occur here, only the shift on pop.
                    if (w_pop) begin
                        w_entry0_nxt = r_entry1;
                        w_cnt_nxt    = 2'd1;
                    end else begin
                        w_cnt_nxt    = 2'd2;
                    end
                end
                default: begin
                    w_cnt_nxt = 2'd0;
                end
            endcase

            // Burst position moves only on accepted beats, so stalls and gaps keep it.
            if (w_pop) begin
                if (r_beat_cnt == LAST_BEAT) begin
                    w_beat_cnt_nxt = {BW{1'b0}};
                end else begin
                    w_beat_cnt_nxt = r_beat_cnt + BW'(1);
                end
            end else begin
                w_beat_cnt_nxt = r_beat_cnt;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            r_cnt      <= 2'd0;
            r_entry0   <= {W{1'b0}};
            r_entry1   <= {W{1'b0}};
            r_beat_cnt <= {BW{1'b0}};
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_entry0   <= w_entry0_nxt;
            r_entry1   <= w_entry1_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural show-ahead FIFO.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_fifo_stream_reader;

    localparam int W  = 8;
    localparam int BL = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fifo_stream_reader_if #(.W(W)) ifc ();

    fifo_stream_reader #(.W(W), .BURST_LEN(BL)) dut (
        .rd_clk     (clk),
        .rd_reset_n (rst_n),
        .bus        (ifc.master)
    );

    // Behavioural FIFO: array plus pointers; hold_empty forces gaps.
    logic [7:0] mem [0:32767];
    int   rd_ptr     = 0;
    int   wr_ptr     = 0;
    logic hold_empty = 1'b1;
    logic fifo_drop  = 1'b0;

    assign ifc.fifo_empty   = hold_empty || (rd_ptr == wr_ptr);
    assign ifc.fifo_rd_data = mem[rd_ptr[14:0]];

    // FIFO read pointer: advances on a pop, or skips to the write pointer on drop.
    always @(posedge clk) begin
        if (fifo_drop) begin
            rd_ptr <= wr_ptr;
        end else if (ifc.fifo_rd_en && !ifc.fifo_empty) begin
            rd_ptr <= rd_ptr + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic push_word(input logic [7:0] v);
        mem[wr_ptr[14:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic start_test();
        @(negedge clk);
        ifc.flush     = 1'b1;
        fifo_drop     = 1'b1;
        ifc.out_ready = 1'b0;
        hold_empty    = 1'b1;
        @(negedge clk);
        ifc.flush = 1'b0;
        fifo_drop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        ifc.flush     = 1'b0;
        ifc.out_ready = 1'b1;
        hold_empty    = 1'b0;
        push_word(8'h55);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (ifc.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", ifc.fifo_rd_en); end
            checks++;
            if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ifc.out_valid); end
            checks++;
            if (ifc.out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", ifc.out_data); end
            checks++;
            if (ifc.out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", ifc.out_last); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ifc.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL first_rd_en: got %b expected 1", ifc.fifo_rd_en); end
        @(negedge clk);
        #1;
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== 8'h55) begin
            errors++; $display("FAIL first_word: got valid=%b data=%h expected valid=1 data=55", ifc.out_valid, ifc.out_data);
        end
    endtask

    task automatic test_burst();
        logic       exp_valid;
        logic       exp_rd;
        logic       exp_last;
        logic [7:0] exp_data;
        start_test();
        for (int i = 0; i < 8; i++) push_word(8'(16 + i));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                hold_empty    = 1'b0;
                ifc.out_ready = 1'b1;
            end
            #1;
            exp_valid = (c >= 1) && (c <= 8);
            exp_rd    = (c <= 7);
            exp_last  = exp_valid && (((c - 1) % 4) == 3);
            exp_data  = 8'(16 + c - 1);
            checks++;
            if (ifc.out_valid !== exp_valid) begin errors++; $display("FAIL burst_valid c=%0d: got %b expected %b", c, ifc.out_valid, exp_valid); end
            checks++;
            if (ifc.fifo_rd_en !== exp_rd) begin errors++; $display("FAIL burst_rd_en c=%0d: got %b expected %b", c, ifc.fifo_rd_en, exp_rd); end
            checks++;
            if (ifc.out_last !== exp_last) begin errors++; $display("FAIL burst_last c=%0d: got %b expected %b", c, ifc.out_last, exp_last); end
            if (exp_valid) begin
                checks++;
                if (ifc.out_data !== exp_data) begin errors++; $display("FAIL burst_data c=%0d: got %h expected %h", c, ifc.out_data, exp_data); end
            end
        end
    endtask

    task automatic test_backpressure();
        int pulses = 0;
        int k      = 0;
        start_test();
        for (int i = 0; i < 6; i++) push_word(8'(16 + i));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                hold_empty    = 1'b0;
                ifc.out_ready = 1'b0;
            end
            #1;
            if (ifc.fifo_rd_en === 1'b1) pulses++;
            if (c >= 1) begin
                checks++;
                if (ifc.out_valid !== 1'b1 || ifc.out_data !== 8'h10) begin
                    errors++; $display("FAIL bp_hold c=%0d: got valid=%b data=%h expected valid=1 data=10", c, ifc.out_valid, ifc.out_data);
                end
            end
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL bp_rd_pulses: got %0d expected 2", pulses); end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) ifc.out_ready = 1'b1;
            #1;
            if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
                checks++;
                if (ifc.out_data !== 8'(16 + k)) begin errors++; $display("FAIL bp_order k=%0d: got %h expected %h", k, ifc.out_data, 8'(16 + k)); end
                checks++;
                if (ifc.out_last !== ((k % 4) == 3)) begin errors++; $display("FAIL bp_last k=%0d: got %b", k, ifc.out_last); end
                k++;
            end
        end
        checks++;
        if (k != 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", k); end
    endtask

    task automatic test_gap();
        logic [7:0] exp_g [4];
        int k = 0;
        exp_g[0] = 8'hA0; exp_g[1] = 8'hA1; exp_g[2] = 8'hA2; exp_g[3] = 8'hA3;
        start_test();
        push_word(8'hA0);
        push_word(8'hA1);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) begin
                hold_empty    = 1'b0;
                ifc.out_ready = 1'b1;
            end
            if (c == 9) begin
                push_word(8'hA2);
                push_word(8'hA3);
            end
            #1;
            if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1 && k < 4) begin
                checks++;
                if (ifc.out_data !== exp_g[k]) begin errors++; $display("FAIL gap_data k=%0d: got %h expected %h", k, ifc.out_data, exp_g[k]); end
                checks++;
                if (ifc.out_last !== (k == 3)) begin errors++; $display("FAIL gap_last k=%0d: got %b expected %b", k, ifc.out_last, (k == 3)); end
                k++;
            end
        end
        checks++;
        if (k != 4) begin errors++; $display("FAIL gap_count: got %0d expected 4", k); end
    endtask

    task automatic test_flush();
        int k = 0;
        start_test();
        for (int i = 0; i < 8; i++) push_word(8'(48 + i));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                hold_empty    = 1'b0;
                ifc.out_ready = 1'b1;
            end
            #1;
            if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) k++;
        end
        checks++;
        if (k != 2) begin errors++; $display("FAIL flush_pre_beats: got %0d expected 2", k); end
        @(negedge clk);
        ifc.out_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.fifo_rd_en !== 1'b0 || ifc.out_data !== 8'h32) begin
            errors++; $display("FAIL flush_full: got valid=%b rd_en=%b data=%h expected 1 0 32", ifc.out_valid, ifc.fifo_rd_en, ifc.out_data);
        end
        @(negedge clk);
        ifc.flush     = 1'b1;
        ifc.out_ready = 1'b1;
        #1;
        checks++;
        if (ifc.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL flush_rd_en: got %b expected 0", ifc.fifo_rd_en); end
        @(negedge clk);
        ifc.flush = 1'b0;
        #1;
        checks++;
        if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", ifc.out_valid); end
        k = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1 && k < 4) begin
                checks++;
                if (ifc.out_data !== 8'(52 + k)) begin errors++; $display("FAIL flush_data k=%0d: got %h expected %h", k, ifc.out_data, 8'(52 + k)); end
                checks++;
                if (ifc.out_last !== (k == 3)) begin errors++; $display("FAIL flush_last k=%0d: got %b expected %b", k, ifc.out_last, (k == 3)); end
                k++;
            end
        end
        checks++;
        if (k != 4) begin errors++; $display("FAIL flush_count: got %0d expected 4", k); end
    endtask

    task automatic test_reset_midburst();
        int k = 0;
        start_test();
        for (int i = 0; i < 8; i++) push_word(8'(64 + i));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                hold_empty    = 1'b0;
                ifc.out_ready = 1'b1;
            end
            if (c == 3) ifc.out_ready = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.out_data !== 8'h00 || ifc.out_last !== 1'b0 || ifc.fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got valid=%b data=%h last=%b rd_en=%b expected all 0",
                               ifc.out_valid, ifc.out_data, ifc.out_last, ifc.fifo_rd_en);
        end
        @(negedge clk);
        rst_n         = 1'b1;
        ifc.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1 && k < 4) begin
                checks++;
                if (ifc.out_data !== 8'(68 + k)) begin errors++; $display("FAIL midrst_data k=%0d: got %h expected %h", k, ifc.out_data, 8'(68 + k)); end
                checks++;
                if (ifc.out_last !== (k == 3)) begin errors++; $display("FAIL midrst_last k=%0d: got %b expected %b", k, ifc.out_last, (k == 3)); end
                k++;
            end
        end
        checks++;
        if (k != 4) begin errors++; $display("FAIL midrst_count: got %0d expected 4", k); end
    endtask

    task automatic test_random();
        int         start;
        int         k = 0;
        logic [7:0] exp_d;
        start_test();
        start = wr_ptr;
        for (int i = 0; i < 12000; i++) push_word(8'($urandom_range(0, 255)));
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            hold_empty    = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (ifc.fifo_rd_en === 1'b1 && ifc.fifo_empty === 1'b1) begin
                errors++; $display("FAIL rnd_underflow c=%0d: got rd_en=1 while empty expected rd_en=0", c);
            end
            if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
                exp_d = mem[(start + k) % 32768];
                checks++;
                if (ifc.out_data !== exp_d) begin errors++; $display("FAIL rnd_data k=%0d: got %h expected %h", k, ifc.out_data, exp_d); end
                checks++;
                if (ifc.out_last !== ((k % 4) == 3)) begin errors++; $display("FAIL rnd_last k=%0d: got %b expected %b", k, ifc.out_last, ((k % 4) == 3)); end
                k++;
            end
        end
        checks++;
        if (k < 3000) begin errors++; $display("FAIL rnd_throughput: got %0d beats expected at least 3000", k); end
    endtask

    initial begin
        ifc.flush     = 1'b0;
        ifc.out_ready = 1'b0;
        test_reset();
        test_burst();
        test_backpressure();
        test_gap();
        test_flush();
        test_reset_midburst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
